// File: rtl/boot_prefetch_if.sv
// Fetch-side and ROM-side signal bundle for the boot prefetcher.
// master = prefetcher, slave = CPU/ROM environment.
interface boot_prefetch_if;
    logic        fetch_redirect;
    logic [14:0] fetch_redirect_addr;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [31:0] fetch_instr;
    logic [14:0] fetch_addr;
    logic        rom_req;
    logic [14:0] rom_addr;
    logic [31:0] rom_rdata;
    logic        rom_ready;

    modport master (
        input  fetch_redirect, fetch_redirect_addr, fetch_ready, rom_rdata, rom_ready,
        output fetch_valid, fetch_instr, fetch_addr, rom_req, rom_addr
    );

    modport slave (
        output fetch_redirect, fetch_redirect_addr, fetch_ready, rom_rdata, rom_ready,
        input  fetch_valid, fetch_instr, fetch_addr, rom_req, rom_addr
    );
endinterface

// File: rtl/boot_prefetch.sv
// Boot ROM instruction prefetcher: credit-limited ROM reads into a DEPTH-entry FIFO.
// Latency: request -> data 1 cycle, data -> fetch_valid 1 cycle (no bypass).
// Backpressure: requests stop once level + in-flight reaches DEPTH; fetch_ready=0 holds the head.
module boot_prefetch #(
    parameter int          DEPTH    = 4,
    parameter logic [14:0] RESET_PC = 15'h0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            mbist_en,
    output logic [3:0]      pf_level,
    boot_prefetch_if.master bus
);
    localparam int            PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST    = PW'(DEPTH - 1);
    localparam logic [3:0]    DEPTH_L = 4'(DEPTH);
    localparam logic [14:0]   ALIGN_M = 15'h7FFC;

    typedef enum logic {RUN, HOLD} state_t;

    state_t        state_q;
    logic [14:0]   cpu_pc_q, cpu_pc_d;
    logic [14:0]   issue_pc_q, issue_pc_d;
    logic          inflight_q, drop_q;
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [3:0]    level_q, level_d;
    logic [31:0]   mem_q [DEPTH];

    logic          active, flush, push, pop;
    logic [14:0]   redir_pc;

    assign redir_pc = bus.fetch_redirect_addr & ALIGN_M;
    assign active   = (state_q == RUN) && !mbist_en;
    assign flush    = !active || bus.fetch_redirect;

    // rst_n gate keeps rom_req low while reset is held even though the request is combinational.
    assign bus.rom_req     = rst_n && active && !bus.fetch_redirect &&
                             ((level_q + 4'(inflight_q)) < DEPTH_L);
    assign bus.rom_addr    = issue_pc_q;
    assign bus.fetch_valid = (level_q != 4'd0) && !flush;
    assign bus.fetch_instr = bus.fetch_valid ? mem_q[head_q] : 32'h0;
    assign bus.fetch_addr  = cpu_pc_q;
    assign pf_level        = level_q;

    assign push = bus.rom_ready && inflight_q && !drop_q && !flush;
    assign pop  = bus.fetch_valid && bus.fetch_ready;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        level_d = level_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            level_d = 4'd0;
        end else begin
            if (push) tail_d = (tail_q == LAST) ? '0 : tail_q + PW'(1);
            if (pop)  head_d = (head_q == LAST) ? '0 : head_q + PW'(1);
            level_d = level_q + 4'(push) - 4'(pop);
        end

        cpu_pc_d = cpu_pc_q;
        if (bus.fetch_redirect) cpu_pc_d = redir_pc;
        else if (pop)           cpu_pc_d = cpu_pc_q + 15'd4;

        // While suspended the issue pointer shadows cpu_pc so resume restarts at the next undelivered word.
        issue_pc_d = issue_pc_q;
        if (!active)                 issue_pc_d = cpu_pc_d;
        else if (bus.fetch_redirect) issue_pc_d = redir_pc;
        else if (bus.rom_req)        issue_pc_d = issue_pc_q + 15'd4;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            cpu_pc_q   <= RESET_PC & ALIGN_M;
            issue_pc_q <= RESET_PC & ALIGN_M;
            inflight_q <= 1'b0;
            drop_q     <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
            level_q    <= 4'd0;
        end else begin
            if (state_q == RUN) begin
                if (mbist_en) state_q <= HOLD;
            end else if (!mbist_en) begin
                state_q <= RUN;
            end
            cpu_pc_q   <= cpu_pc_d;
            issue_pc_q <= issue_pc_d;
            inflight_q <= bus.rom_req;
            drop_q     <= bus.fetch_redirect && active;
            head_q     <= head_d;
            tail_q     <= tail_d;
            level_q    <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[tail_q] <= bus.rom_rdata;
    end
endmodule

// File: tb/tb_boot_prefetch.sv
// Directed bench for boot_prefetch: vector table for streaming/backpressure/redirect/wrap,
// hand sequences for async reset, MBIST hold/resume and spurious rom_ready.
module tb_boot_prefetch;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       mbist_en = 1'b0;
    logic [3:0] pf_level;
    logic       spur = 1'b0;
    logic       rom_ready_q = 1'b0;
    logic [31:0] rdata_q = 32'h0;

    int total = 0;
    int bad   = 0;

    boot_prefetch_if bus();

    boot_prefetch #(.DEPTH(4), .RESET_PC(15'h0000)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mbist_en (mbist_en),
        .pf_level (pf_level),
        .bus      (bus.master)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] romw(input logic [14:0] a);
        return {a, ~a, 2'b01};
    endfunction

    // ROM model: data and ready exactly one cycle after the request
    always @(posedge clk) begin
        rom_ready_q <= bus.rom_req;
        rdata_q     <= romw(bus.rom_addr);
    end
    assign bus.rom_ready = rom_ready_q | spur;
    assign bus.rom_rdata = rdata_q;

    typedef struct {
        logic        redir;
        logic [14:0] raddr;
        logic        rdy;
        logic        v;
        logic [14:0] fa;
        logic [3:0]  lvl;
        logic        req;
        logic [14:0] ra;
    } vec_t;

    vec_t tbl[27];

    function automatic vec_t vec(input logic redir, input logic [14:0] raddr, input logic rdy,
                                 input logic v, input logic [14:0] fa, input logic [3:0] lvl,
                                 input logic req, input logic [14:0] ra);
        vec_t r;
        r.redir = redir; r.raddr = raddr; r.rdy = rdy;
        r.v = v; r.fa = fa; r.lvl = lvl; r.req = req; r.ra = ra;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic redir, input logic [14:0] raddr, input logic rdy, input logic mb);
        bus.fetch_redirect      = redir;
        bus.fetch_redirect_addr = raddr;
        bus.fetch_ready         = rdy;
        mbist_en                = mb;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [14:0] ea;

        tbl[0]  = vec(0, 15'h0000, 1, 0, 15'h0000, 0, 1, 15'h0000);
        tbl[1]  = vec(0, 15'h0000, 1, 0, 15'h0000, 0, 1, 15'h0004);
        tbl[2]  = vec(0, 15'h0000, 1, 1, 15'h0000, 1, 1, 15'h0008);
        tbl[3]  = vec(0, 15'h0000, 1, 1, 15'h0004, 1, 1, 15'h000C);
        tbl[4]  = vec(0, 15'h0000, 1, 1, 15'h0008, 1, 1, 15'h0010);
        tbl[5]  = vec(0, 15'h0000, 1, 1, 15'h000C, 1, 1, 15'h0014);
        tbl[6]  = vec(0, 15'h0000, 0, 1, 15'h0010, 1, 1, 15'h0018);
        tbl[7]  = vec(0, 15'h0000, 0, 1, 15'h0010, 2, 1, 15'h001C);
        tbl[8]  = vec(0, 15'h0000, 0, 1, 15'h0010, 3, 0, 15'h0020);
        tbl[9]  = vec(0, 15'h0000, 0, 1, 15'h0010, 4, 0, 15'h0020);
        tbl[10] = vec(0, 15'h0000, 0, 1, 15'h0010, 4, 0, 15'h0020);
        tbl[11] = vec(0, 15'h0000, 1, 1, 15'h0010, 4, 0, 15'h0020);
        tbl[12] = vec(0, 15'h0000, 1, 1, 15'h0014, 3, 1, 15'h0020);
        tbl[13] = vec(0, 15'h0000, 1, 1, 15'h0018, 2, 1, 15'h0024);
        tbl[14] = vec(0, 15'h0000, 1, 1, 15'h001C, 2, 1, 15'h0028);
        tbl[15] = vec(1, 15'h1236, 1, 0, 15'h0020, 2, 0, 15'h002C);
        tbl[16] = vec(0, 15'h0000, 1, 0, 15'h1234, 0, 1, 15'h1234);
        tbl[17] = vec(0, 15'h0000, 1, 0, 15'h1234, 0, 1, 15'h1238);
        tbl[18] = vec(0, 15'h0000, 1, 1, 15'h1234, 1, 1, 15'h123C);
        tbl[19] = vec(0, 15'h0000, 1, 1, 15'h1238, 1, 1, 15'h1240);
        tbl[20] = vec(1, 15'h7FFB, 1, 0, 15'h123C, 1, 0, 15'h1244);
        tbl[21] = vec(0, 15'h0000, 1, 0, 15'h7FF8, 0, 1, 15'h7FF8);
        tbl[22] = vec(0, 15'h0000, 1, 0, 15'h7FF8, 0, 1, 15'h7FFC);
        tbl[23] = vec(0, 15'h0000, 1, 1, 15'h7FF8, 1, 1, 15'h0000);
        tbl[24] = vec(0, 15'h0000, 1, 1, 15'h7FFC, 1, 1, 15'h0004);
        tbl[25] = vec(0, 15'h0000, 1, 1, 15'h0000, 1, 1, 15'h0008);
        tbl[26] = vec(0, 15'h0000, 1, 1, 15'h0004, 1, 1, 15'h000C);

        drive(0, 15'h0, 0, 0);
        repeat (2) @(negedge clk);
        #1;
        chk("rst_valid", bus.fetch_valid, 0);
        chk("rst_instr", bus.fetch_instr, 0);
        chk("rst_req",   bus.rom_req, 0);
        chk("rst_level", pf_level, 0);
        chk("rst_faddr", bus.fetch_addr, 15'h0000);
        chk("rst_raddr", bus.rom_addr, 15'h0000);

        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 27; i++) begin
            drive(tbl[i].redir, tbl[i].raddr, tbl[i].rdy, 0);
            #1;
            chk($sformatf("row%0d_valid", i), bus.fetch_valid, tbl[i].v);
            chk($sformatf("row%0d_faddr", i), bus.fetch_addr, tbl[i].fa);
            chk($sformatf("row%0d_level", i), pf_level, tbl[i].lvl);
            chk($sformatf("row%0d_req", i),   bus.rom_req, tbl[i].req);
            chk($sformatf("row%0d_raddr", i), bus.rom_addr, tbl[i].ra);
            chk($sformatf("row%0d_instr", i), bus.fetch_instr, tbl[i].v ? romw(tbl[i].fa) : 32'h0);
            @(negedge clk);
        end

        // asynchronous reset mid-stream discards everything at once
        rst_n = 1'b0;
        #1;
        chk("midrst_level", pf_level, 0);
        chk("midrst_valid", bus.fetch_valid, 0);
        chk("midrst_req",   bus.rom_req, 0);
        chk("midrst_faddr", bus.fetch_addr, 15'h0000);
        chk("midrst_raddr", bus.rom_addr, 15'h0000);

        // MBIST: three handshakes (0,4,8), two words buffered, then 10 cycles of HOLD
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        drive(0, 15'h0, 1, 0);
        repeat (5) @(negedge clk);
        drive(0, 15'h0, 0, 0);
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            drive(0, 15'h0, 0, 1);
            #1;
            chk($sformatf("hold%0d_req", i),   bus.rom_req, 0);
            chk($sformatf("hold%0d_valid", i), bus.fetch_valid, 0);
            chk($sformatf("hold%0d_faddr", i), bus.fetch_addr, 15'h000C);
            chk($sformatf("hold%0d_level", i), pf_level, (i == 0) ? 4'd2 : 4'd0);
            @(negedge clk);
        end
        drive(0, 15'h0, 1, 0);
        #1;
        chk("exit_req",   bus.rom_req, 0);
        chk("exit_valid", bus.fetch_valid, 0);
        @(negedge clk); #1;
        chk("resume_req0",   bus.rom_req, 1);
        chk("resume_raddr0", bus.rom_addr, 15'h000C);
        @(negedge clk); #1;
        chk("resume_raddr1", bus.rom_addr, 15'h0010);
        chk("resume_valid1", bus.fetch_valid, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            ea = 15'h000C + 15'(4 * i);
            chk($sformatf("resume%0d_valid", i), bus.fetch_valid, 1);
            chk($sformatf("resume%0d_faddr", i), bus.fetch_addr, ea);
            chk($sformatf("resume%0d_instr", i), bus.fetch_instr, romw(ea));
        end

        // fill with fetch_ready low, then a spurious rom_ready must not change the level
        @(negedge clk);
        drive(0, 15'h0, 0, 0);
        #1;
        n = 0;
        while (pf_level != 4'd4 && n < 10) begin
            @(negedge clk); #1;
            n++;
        end
        chk("fill_level", pf_level, 4);
        @(negedge clk); #1;
        chk("full_req", bus.rom_req, 0);
        spur = 1'b1;
        @(negedge clk);
        spur = 1'b0;
        #1;
        chk("spur_level", pf_level, 4);
        chk("spur_faddr", bus.fetch_addr, 15'h0018);
        drive(0, 15'h0, 1, 0);
        for (int i = 0; i < 4; i++) begin
            #1;
            ea = 15'h0018 + 15'(4 * i);
            chk($sformatf("drain%0d_valid", i), bus.fetch_valid, 1);
            chk($sformatf("drain%0d_faddr", i), bus.fetch_addr, ea);
            chk($sformatf("drain%0d_instr", i), bus.fetch_instr, romw(ea));
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
